// File: rtl/pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl
//
// Purpose:
//   Sequences one rPLL that has dynamic IDSEL/FBDSEL/ODSEL dividers.
//   Each attempt holds the PLL in reset, waits for lock and then qualifies it.
//   A lock timeout triggers a retry; once the retries are used up the block
//   parks in FAIL. While the PLL is locked (RUN), and also while in FAIL,
//   divider-change requests are taken through a req/ack handshake.
//   The block runs in the PLL reference clock domain.
//
// Ports:
//   clkin_i       reference clock (same net as PLL CLKIN)
//   reset_i       asynchronous, active-high reset
//   cfg_req_i     divider-change request, held until cfg_ack_o
//   cfg_*sel_i    requested divider codes (passed through unmodified)
//   cfg_ack_o     1-cycle pulse: request latched
//   pll_lock_i    raw PLL LOCK (asynchronous to clkin_i)
//   pll_reset_o   PLL RESET
//   pll_*sel_o    PLL divider codes
//   locked_o      qualified lock
//   busy_o        sequence in progress, requests are ignored
//   fail_o        retries exhausted (sticky until a request is accepted)
//   lock_lost_o   1-cycle pulse when lock drops in RUN
//
// States:
//   state         | meaning
//   ST_RST_HOLD   | pll_reset high, counting RST_HOLD_CYC cycles
//   ST_WAIT_LOCK  | reset released, waiting for synced lock
//   ST_STABLE_CHK | synced lock high, counting consecutive cycles
//   ST_RUN        | qualified lock, requests accepted
//   ST_FAIL       | retries exhausted, PLL held in reset, requests accepted
// ---------------------------------------------------------------------------
module pll_reconfig_ctrl #(
    parameter int unsigned RST_HOLD_CYC     = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
    parameter int unsigned MAX_RETRY        = 3,
    parameter logic [5:0]  DEF_IDSEL        = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL       = 6'd0,
    parameter logic [5:0]  DEF_ODSEL        = 6'd0
) (
    input  logic       clkin_i,
    input  logic       reset_i,
    input  logic       cfg_req_i,
    input  logic [5:0] cfg_idsel_i,
    input  logic [5:0] cfg_fbdsel_i,
    input  logic [5:0] cfg_odsel_i,
    output logic       cfg_ack_o,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [5:0] pll_idsel_o,
    output logic [5:0] pll_fbdsel_o,
    output logic [5:0] pll_odsel_o,
    output logic       locked_o,
    output logic       busy_o,
    output logic       fail_o,
    output logic       lock_lost_o
);

    localparam int HW = $clog2(RST_HOLD_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE_CHK,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [SW-1:0]   stable_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic [RW-1:0]   retry_q;
    logic            lock_meta_q;
    logic            lock_s_q;
    logic            cfg_ack_q;
    logic            pll_reset_q;
    logic [5:0]      idsel_q;
    logic [5:0]      fbdsel_q;
    logic [5:0]      odsel_q;
    logic            locked_q;
    logic            busy_q;
    logic            fail_q;
    logic            lock_lost_q;

    // Two-flop synchronizer for the raw PLL lock.
    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RST_HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            to_cnt_q     <= '0;
            retry_q      <= '0;
            cfg_ack_q    <= 1'b0;
            pll_reset_q  <= 1'b1;
            idsel_q      <= DEF_IDSEL;
            fbdsel_q     <= DEF_FBDSEL;
            odsel_q      <= DEF_ODSEL;
            locked_q     <= 1'b0;
            busy_q       <= 1'b1;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            cfg_ack_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            case (state_q)
                ST_RST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q  <= '0;
                        to_cnt_q    <= '0;
                        pll_reset_q <= 1'b0;
                        state_q     <= ST_WAIT_LOCK;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK, ST_STABLE_CHK: begin
                    // Qualifying on the very cycle the timeout would expire
                    // still counts as a lock.
                    if (state_q == ST_STABLE_CHK && lock_s_q && stable_cnt_q == STABLE_LAST) begin
                        stable_cnt_q <= '0;
                        locked_q     <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_RUN;
                    end else if (to_cnt_q == TO_LAST) begin
                        stable_cnt_q <= '0;
                        to_cnt_q     <= '0;
                        pll_reset_q  <= 1'b1;
                        if (retry_q < RETRY_MAX) begin
                            retry_q    <= retry_q + 1'b1;
                            hold_cnt_q <= '0;
                            state_q    <= ST_RST_HOLD;
                        end else begin
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FAIL;
                        end
                    end else begin
                        // Timeout keeps running across WAIT_LOCK/STABLE_CHK bounces.
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (state_q == ST_WAIT_LOCK) begin
                            if (lock_s_q) begin
                                stable_cnt_q <= '0;
                                state_q      <= ST_STABLE_CHK;
                            end
                        end else if (!lock_s_q) begin
                            stable_cnt_q <= '0;
                            state_q      <= ST_WAIT_LOCK;
                        end else begin
                            stable_cnt_q <= stable_cnt_q + 1'b1;
                        end
                    end
                end

                ST_RUN, ST_FAIL: begin
                    if (state_q == ST_RUN && !lock_s_q) begin
                        locked_q    <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end
                    if (cfg_req_i || (state_q == ST_RUN && !lock_s_q)) begin
                        retry_q     <= '0;
                        hold_cnt_q  <= '0;
                        pll_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_RST_HOLD;
                    end
                    // New codes appear on the same edge that raises pll_reset,
                    // so the PLL only ever sees them while held in reset.
                    if (cfg_req_i) begin
                        idsel_q   <= cfg_idsel_i;
                        fbdsel_q  <= cfg_fbdsel_i;
                        odsel_q   <= cfg_odsel_i;
                        cfg_ack_q <= 1'b1;
                        fail_q    <= 1'b0;
                        locked_q  <= 1'b0;
                    end
                end

                default: begin
                    hold_cnt_q  <= '0;
                    pll_reset_q <= 1'b1;
                    locked_q    <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= ST_RST_HOLD;
                end
            endcase
        end
    end

    assign cfg_ack_o    = cfg_ack_q;
    assign pll_reset_o  = pll_reset_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_odsel_o  = odsel_q;
    assign locked_o     = locked_q;
    assign busy_o       = busy_q;
    assign fail_o       = fail_q;
    assign lock_lost_o  = lock_lost_q;

endmodule
